// File: rtl/riscv_mem_pkg.sv
// Shared memory-map constants, STATUS layout and address decode for the data memory unit.
// The console FIFO itself is optional and is built only when DMEM_CONSOLE_FIFO_EN is defined.
package riscv_mem_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h1000_0000;
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'h0000_0000;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h0000_0004;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h0000_0008;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;

    typedef enum logic [2:0] {
        REG_RAM    = 3'd0,
        REG_TXDATA = 3'd1,
        REG_STATUS = 3'd2,
        REG_CYCLE  = 3'd3,
        REG_NONE   = 3'd4
    } region_e;

    function automatic region_e decode_region(input logic [31:0] addr, input logic [31:0] depth_words);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        if ({2'b00, addr[31:2]} < depth_words) begin
            decode_region = REG_RAM;
        end else if (word_addr == TXDATA_ADDR) begin
            decode_region = REG_TXDATA;
        end else if (word_addr == STATUS_ADDR) begin
            decode_region = REG_STATUS;
        end else if (word_addr == CYCLE_ADDR) begin
            decode_region = REG_CYCLE;
        end else begin
            decode_region = REG_NONE;
        end
    endfunction

    function automatic logic [31:0] build_status(input logic full, input logic empty,
                                                  input logic ovf, input logic [3:0] count);
        build_status = 32'h0000_0000;
        build_status[STATUS_FULL_BIT]             = full;
        build_status[STATUS_EMPTY_BIT]            = empty;
        build_status[STATUS_OVF_BIT]              = ovf;
        build_status[STATUS_COUNT_LSB +: 4]       = count;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console transmit byte FIFO (power-of-two depth); exists only when DMEM_CONSOLE_FIFO_EN is defined.
// A push while full is accepted only if a pop frees the head slot in the same cycle.
`ifdef DMEM_CONSOLE_FIFO_EN
module tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [7:0]    r_buf [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == {(PW + 1){1'b0}});
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign count  = r_count;
    assign dout   = empty ? 8'h00 : r_buf[r_rd_ptr];

    // Byte storage; contents are meaningless while the slot is not between the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`endif

// File: rtl/data_mem_unit.sv
// Data memory for the core M stage: word RAM, free-running cycle counter and console MMIO.
// Define DMEM_CONSOLE_FIFO_EN to build the console TX FIFO; otherwise TX ports are tied off.
module data_mem_unit
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteData,
    input  logic [31:0] mask,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_cycle;
    logic [AW-1:0] w_idx;
    region_e       w_region;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic          w_unused_ok;

    assign w_region = decode_region(ALUResultM, 32'(DEPTH_WORDS));
    assign w_idx    = ALUResultM[AW+1:2];
    assign ReadData = w_rdata;

    // RAM is deliberately left out of reset so stored data survives a core reset.
    always_ff @(posedge clk) begin
        if (MemWrite && (w_region == REG_RAM)) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~mask) | (WriteData & mask);
        end
    end

    // Free-running cycle counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= 32'h0000_0000;
        end else begin
            r_cycle <= r_cycle + 32'h0000_0001;
        end
    end

    // Zero-latency load path so the core sees data in the same M-stage cycle.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_region)
            REG_RAM:    w_rdata = r_mem[w_idx];
            REG_STATUS: w_rdata = w_status;
            REG_CYCLE:  w_rdata = r_cycle;
            default:    w_rdata = 32'h0000_0000;
        endcase
    end

`ifdef DMEM_CONSOLE_FIFO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_fifo_data;
    logic          r_overflow;

    assign w_push = MemWrite && (w_region == REG_TXDATA) && (mask[7:0] != 8'h00);
    assign w_pop  = tx_ready && !w_empty;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (w_push),
        .pop   (tx_ready),
        .din   (WriteData[7:0]),
        .dout  (w_fifo_data),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Sticky overflow: set by a dropped push, cleared by any store to STATUS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (MemWrite && (w_region == REG_STATUS)) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign w_status    = build_status(w_full, w_empty, r_overflow, 4'(w_count));
    assign tx_valid    = !w_empty;
    assign tx_data     = w_fifo_data;
    assign w_unused_ok = ^ALUResultM[1:0];
`else
    assign w_status    = build_status(1'b0, 1'b1, 1'b0, 4'h0);
    assign tx_valid    = 1'b0;
    assign tx_data     = 8'h00;
    assign w_unused_ok = ^{tx_ready, ALUResultM[1:0], (FIFO_DEPTH > 1)};
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: directed steps plus random traffic against a queue/array model.
// Console checks follow DMEM_CONSOLE_FIFO_EN, matching how the design was built.
module tb_data_mem_unit;
    localparam int DW = 256;
    localparam int FD = 4;
    localparam logic [31:0] A_TX   = 32'h1000_0000;
    localparam logic [31:0] A_ST   = 32'h1000_0004;
    localparam logic [31:0] A_CY   = 32'h1000_0008;
    localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResultM;
    logic [31:0] WriteData;
    logic [31:0] mask;
    logic [31:0] ReadData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int fails  = 0;

    logic [31:0] m_mem [DW];
    bit          m_valid [DW];
    logic [31:0] m_cycle;
    logic [7:0]  m_q [$];
    bit          m_ovf;

    data_mem_unit #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .ALUResultM (ALUResultM),
        .WriteData  (WriteData),
        .mask       (mask),
        .ReadData   (ReadData),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
`ifdef DMEM_CONSOLE_FIFO_EN
        logic [31:0] s;
        s = 32'h0;
        s[0]   = (m_q.size() == FD);
        s[1]   = (m_q.size() == 0);
        s[2]   = m_ovf;
        s[7:4] = 4'(m_q.size());
        return s;
`else
        return 32'h0000_0002;
`endif
    endfunction

    // Returns 1 when the load value is defined; unwritten RAM words are not checked.
    function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] al;
        int w;
        al = a & 32'hFFFF_FFFC;
        w  = int'(a >> 2);
        v  = 32'h0;
        if (a < 32'(DW * 4)) begin
            v = m_mem[w];
            return m_valid[w];
        end
        if (al == A_CY) v = m_cycle;
        else if (al == A_ST) v = m_status();
        return 1'b1;
    endfunction

    task automatic check_outputs();
        logic [31:0] v;
        bit def;
        def = exp_read(ALUResultM, v);
        if (def) check("rdata", ReadData, v);
`ifdef DMEM_CONSOLE_FIFO_EN
        check("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
        check("tx_data", {24'h0, tx_data}, (m_q.size() != 0) ? {24'h0, m_q[0]} : 32'h0);
`else
        check("tx_valid_tied", {31'h0, tx_valid}, 32'h0);
        check("tx_data_tied", {24'h0, tx_data}, 32'h0);
`endif
    endtask

    task automatic model_edge();
        logic [31:0] al;
        int w;
        al = ALUResultM & 32'hFFFF_FFFC;
        m_cycle = m_cycle + 32'h1;
        if (MemWrite && (ALUResultM < 32'(DW * 4))) begin
            w = int'(ALUResultM >> 2);
            m_mem[w]   = (m_mem[w] & ~mask) | (WriteData & mask);
            m_valid[w] = m_valid[w] || (mask == ONES);
        end
`ifdef DMEM_CONSOLE_FIFO_EN
        begin
            bit pop;
            bit push;
            pop  = tx_ready && (m_q.size() > 0);
            push = MemWrite && (al == A_TX) && (mask[7:0] != 8'h00);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < FD) m_q.push_back(WriteData[7:0]);
                else m_ovf = 1'b1;
            end
            if (MemWrite && (al == A_ST)) m_ovf = 1'b0;
        end
`endif
    endtask

    task automatic tick(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] mk, input logic rdy);
        MemWrite = we; ALUResultM = a; WriteData = wd; mask = mk; tx_ready = rdy;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic peek(input logic [31:0] a);
        MemWrite = 1'b0; ALUResultM = a;
        #1;
    endtask

    task automatic do_reset();
        MemWrite = 1'b0;
        reset = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_cycle = 32'h0;
        #1;
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        ALUResultM = A_ST; #1;
        check("rst_status", ReadData, 32'h0000_0002);
        ALUResultM = A_CY; #1;
        check("rst_cycle", ReadData, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; ALUResultM = 32'h0; WriteData = 32'h0;
        mask = 32'h0; tx_ready = 1'b0; m_cycle = 32'h0; m_ovf = 1'b0;
        #2;
        do_reset();

        repeat (10) tick(1'b0, A_CY, 32'h0, 32'h0, 1'b0);
        peek(A_CY);
        check("cycle_10", ReadData, 32'd10);

        tick(1'b1, 32'h10, 32'hAABB_CCDD, ONES, 1'b0);
        tick(1'b1, 32'h10, 32'h1122_3344, 32'h0000_FF00, 1'b0);
        peek(32'h10);
        check("byte_mask", ReadData, 32'hAABB_33DD);
        tick(1'b1, 32'h12, ONES, 32'h0, 1'b0);
        peek(32'h10);
        check("mask_zero", ReadData, 32'hAABB_33DD);

        tick(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, ONES, 1'b0);
        peek(32'h2000_0000);
        check("unmapped", ReadData, 32'h0);
        tick(1'b1, A_CY, 32'h0, ONES, 1'b0);
        tick(1'b0, A_CY, 32'h0, 32'h0, 1'b0);
        peek(A_TX);
        check("txdata_read", ReadData, 32'h0);

`ifdef DMEM_CONSOLE_FIFO_EN
        repeat (6) tick(1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        tick(1'b1, A_ST, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, A_TX, 32'h41 + 32'(i), 32'h0000_00FF, 1'b0);
        peek(A_ST);
        check("fifo_status", ReadData, 32'h0000_0045);
        check("fifo_head", {24'h0, tx_data}, 32'h41);
        repeat (4) tick(1'b0, A_ST, 32'h0, 32'h0, 1'b1);
        peek(A_ST);
        check("drained_valid", {31'h0, tx_valid}, 32'h0);
        check("drained_empty", {31'h0, ReadData[1]}, 32'h1);
        tick(1'b1, A_ST, ONES, ONES, 1'b0);
        peek(A_ST);
        check("ovf_clear", ReadData, 32'h0000_0002);

        for (int i = 0; i < 4; i++) tick(1'b1, A_TX, 32'h01 + 32'(i), 32'h0000_00FF, 1'b0);
        tick(1'b1, A_TX, 32'h5A, 32'h0000_00FF, 1'b1);
        peek(A_ST);
        check("full_pushpop", ReadData, 32'h0000_0041);
        repeat (3) tick(1'b0, A_ST, 32'h0, 32'h0, 1'b1);
        peek(A_ST);
        check("5a_fourth", {24'h0, tx_data}, 32'h5A);
        repeat (2) tick(1'b0, A_ST, 32'h0, 32'h0, 1'b1);

        tick(1'b1, A_TX, 32'h77, 32'h0000_00FF, 1'b1);
        peek(A_ST);
        check("empty_pushpop", {23'h0, tx_valid, tx_data}, 32'h177);
        tick(1'b1, A_TX, 32'h99, 32'hFFFF_FF00, 1'b0);
        tick(1'b0, A_ST, 32'h0, 32'h0, 1'b1);
`else
        tick(1'b1, A_TX, 32'h41, 32'h0000_00FF, 1'b0);
        peek(A_ST);
        check("tx_off_valid", {31'h0, tx_valid}, 32'h0);
        check("tx_off_status", ReadData, 32'h0000_0002);
        tick(1'b1, A_ST, ONES, ONES, 1'b0);
        peek(A_ST);
        check("tx_off_stwr", ReadData, 32'h0000_0002);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] mk;
            logic        we;
            int unsigned r;
            r  = $urandom_range(0, 9);
            wd = $urandom;
            mk = ($urandom_range(0, 2) == 0) ? 32'($urandom) : ONES;
            we = 1'b0;
            a  = 32'($urandom_range(0, DW * 4 - 1));
            if (r <= 3) we = 1'b1;
            else if (r <= 6) we = 1'b0;
            else if (r == 7) begin
                a = A_TX; we = 1'b1;
                if ($urandom_range(0, 3) == 0) mk = 32'hFFFF_FF00;
            end else if (r == 8) begin
                a = A_ST | 32'($urandom_range(0, 3)); we = ($urandom_range(0, 3) == 0);
            end else begin
                case ($urandom_range(0, 4))
                    0:       a = 32'h0000_0400;
                    1:       a = 32'h2000_0000;
                    2:       a = 32'h1000_000C;
                    3:       a = 32'hFFFF_FFFC;
                    default: a = 32'h1000_000B;
                endcase
                we = 1'($urandom_range(0, 1));
            end
            tick(we, a, wd, mk, ($urandom_range(0, 2) == 0));
        end

`ifdef DMEM_CONSOLE_FIFO_EN
        repeat (3) tick(1'b1, A_TX, 32'h61, 32'h0000_00FF, 1'b0);
        tick(1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        peek(A_ST);
        check("mid_drain_valid", {31'h0, tx_valid}, 32'h1);
`endif
        do_reset();
        tick(1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        peek(32'h10);
        if (m_valid[4]) check("ram_keep", ReadData, m_mem[4]);
        repeat (3) tick(1'b0, A_CY, 32'h0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
